dna_search_scheduler: RTL and testbench

//  Shares one DNA pattern-search engine between NUM_REQ requesters.
//  - Arbitrates round-robin, latches the winner's job operands and pulses the engine's ready.
//  - Waits for the engine's done and returns found/location/error to the winning requester.
//  - Sits between the host-side request ports and a single search datapath.

---
 rtl/search_sched_pkg.sv | 26 ++
 rtl/dna_search_scheduler_rr_arbiter.sv | 35 +++
 rtl/dna_search_scheduler.sv | 152 +++++++++++++++
 tb/tb_dna_search_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/search_sched_pkg.sv
// Shared types for the DNA search scheduler: FSM states, job operands and engine results.
package search_sched_pkg;

    localparam int DNA_AW = 16;
    localparam int PAT_AW = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic [DNA_AW-1:0] dna_start;
        logic [DNA_AW-1:0] dna_len;
        logic [PAT_AW-1:0] pat_start;
    } job_t;

    typedef struct packed {
        logic              found;
        logic              error;
        logic [DNA_AW-1:0] location;
    } result_t;

endpackage

// File: rtl/dna_search_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at NUM_REQ.
// Purely combinational; no backpressure of its own.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    always_comb begin
        logic [IW:0]   k;
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        k         = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(NUM_REQ))
                k = k - (IW+1)'(NUM_REQ);
            idx = k[IW-1:0];
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dna_search_scheduler.sv
// Shares one DNA search engine between NUM_REQ requesters, round-robin, one job at a time.
// Latency: req in IDLE at t -> ack/eng_ready at t+1; eng_done at w -> resp_valid at w+1.
// Backpressure: req is level-held until req_ack; SEARCH_TIMEOUT_EN adds an engine watchdog.
module dna_search_scheduler
    import search_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*16-1:0]    req_dna_start,
    input  logic [NUM_REQ*16-1:0]    req_dna_len,
    input  logic [NUM_REQ*12-1:0]    req_pat_start,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic                     resp_found,
    output logic                     resp_error,
    output logic [DNA_AW-1:0]        resp_location,
    output logic                     eng_ready,
    output logic [DNA_AW-1:0]        eng_dna_start,
    output logic [DNA_AW-1:0]        eng_dna_len,
    output logic [PAT_AW-1:0]        eng_pat_start,
    output logic                     eng_reset,
    input  logic                     eng_done,
    input  logic                     eng_found_it,
    input  logic                     eng_error,
    input  logic [DNA_AW-1:0]        eng_location
);

    localparam int IW = $clog2(NUM_REQ);

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        gidx;
    logic [NUM_REQ-1:0]   gnt;
    job_t                 job;
    job_t                 cand;
    result_t              res;
    logic                 zero_job;
    logic                 timed_out;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_gnt),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        cand.dna_start = req_dna_start[int'(arb_idx)*DNA_AW +: DNA_AW];
        cand.dna_len   = req_dna_len[int'(arb_idx)*DNA_AW +: DNA_AW];
        cand.pat_start = req_pat_start[int'(arb_idx)*PAT_AW +: PAT_AW];
    end

`ifdef SEARCH_TIMEOUT_EN
    logic [15:0] wdog;

    always_ff @(posedge clock) begin
        if (reset)
            wdog <= '0;
        else if (state == LAUNCH)
            wdog <= '0;
        else if (state == WAIT && !timed_out)
            wdog <= wdog + 16'd1;
    end

    assign timed_out = (state == WAIT) && (wdog == 16'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gidx     <= '0;
            gnt      <= '0;
            job      <= '0;
            res      <= '0;
            zero_job <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gidx     <= arb_idx;
                        gnt      <= arb_gnt;
                        job      <= cand;
                        res      <= '0;
                        zero_job <= (cand.dna_len == '0);
                        // Zero-length jobs never reach the engine; they are reported as errors.
                        if (cand.dna_len == '0) begin
                            res.error <= 1'b1;
                            state     <= REPORT;
                        end else begin
                            state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (eng_done) begin
                        res.found    <= eng_found_it;
                        res.error    <= eng_error;
                        res.location <= eng_location;
                        state        <= REPORT;
                    end else if (timed_out) begin
                        res.found    <= 1'b0;
                        res.error    <= 1'b1;
                        res.location <= '0;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    rr_ptr   <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                    zero_job <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack       = '0;
        resp_valid    = '0;
        resp_found    = 1'b0;
        resp_error    = 1'b0;
        resp_location = '0;
        eng_ready     = (state == LAUNCH);
        if (state == LAUNCH || (state == REPORT && zero_job))
            req_ack = gnt;
        if (state == REPORT) begin
            resp_valid    = gnt;
            resp_found    = res.found;
            resp_error    = res.error;
            resp_location = res.found ? res.location : '0;
        end
    end

    assign eng_dna_start = job.dna_start;
    assign eng_dna_len   = job.dna_len;
    assign eng_pat_start = job.pat_start;
    assign eng_reset     = reset | (timed_out & ~eng_done);

endmodule

// File: tb/tb_dna_search_scheduler.sv
// Directed bench for dna_search_scheduler; the engine is played by the stimulus sequence.
module tb_dna_search_scheduler;

`ifdef SEARCH_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif
    localparam int N = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*16-1:0]   req_dna_start;
    logic [N*16-1:0]   req_dna_len;
    logic [N*12-1:0]   req_pat_start;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      resp_valid;
    logic              resp_found;
    logic              resp_error;
    logic [15:0]       resp_location;
    logic              eng_ready;
    logic [15:0]       eng_dna_start;
    logic [15:0]       eng_dna_len;
    logic [11:0]       eng_pat_start;
    logic              eng_reset;
    logic              eng_done;
    logic              eng_found_it;
    logic              eng_error;
    logic [15:0]       eng_location;

    int n_cmp = 0;
    int n_bad = 0;

    dna_search_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_dna_start (req_dna_start),
        .req_dna_len   (req_dna_len),
        .req_pat_start (req_pat_start),
        .req_ack       (req_ack),
        .resp_valid    (resp_valid),
        .resp_found    (resp_found),
        .resp_error    (resp_error),
        .resp_location (resp_location),
        .eng_ready     (eng_ready),
        .eng_dna_start (eng_dna_start),
        .eng_dna_len   (eng_dna_len),
        .eng_pat_start (eng_pat_start),
        .eng_reset     (eng_reset),
        .eng_done      (eng_done),
        .eng_found_it  (eng_found_it),
        .eng_error     (eng_error),
        .eng_location  (eng_location)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] s, input logic [15:0] l, input logic [11:0] p);
        req_dna_start[i*16 +: 16] = s;
        req_dna_len[i*16 +: 16]   = l;
        req_pat_start[i*12 +: 12] = p;
    endtask

    task automatic engine(input logic d, input logic f, input logic e, input logic [15:0] loc);
        eng_done     = d;
        eng_found_it = f;
        eng_error    = e;
        eng_location = loc;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0] rr_exp [5];
        reset = 1'b1;
        req = '0;
        req_dna_start = '0;
        req_dna_len = '0;
        req_pat_start = '0;
        engine(1'b0, 1'b0, 1'b0, 16'h0);

        // Reset state
        step();
        chk("rst_eng_reset", 32'(eng_reset), 32'd1);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_eng_ready", 32'(eng_ready), 32'd0);
        chk("rst_eng_dna_start", 32'(eng_dna_start), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_eng_reset", 32'(eng_reset), 32'd0);

        // Single job on requester 1, engine done 20 cycles after eng_ready
        set_op(1, 16'h0010, 16'd32, 12'h004);
        req[1] = 1'b1;
        step();
        chk("job1_ack", 32'(req_ack), 32'b0010);
        chk("job1_eng_ready", 32'(eng_ready), 32'd1);
        chk("job1_dna_start", 32'(eng_dna_start), 32'h0010);
        chk("job1_dna_len", 32'(eng_dna_len), 32'd32);
        chk("job1_pat_start", 32'(eng_pat_start), 32'h004);
        req[1] = 1'b0;
        step();
        chk("job1_ready_one_cycle", 32'(eng_ready), 32'd0);
        chk("job1_ack_one_cycle", 32'(req_ack), 32'd0);
        for (int c = 0; c < 19; c++) step();
        chk("job1_no_early_resp", 32'(resp_valid), 32'd0);
        engine(1'b1, 1'b1, 1'b0, 16'h0017);
        step();
        engine(1'b0, 1'b0, 1'b0, 16'h0);
        chk("job1_resp_valid", 32'(resp_valid), 32'b0010);
        chk("job1_found", 32'(resp_found), 32'd1);
        chk("job1_error", 32'(resp_error), 32'd0);
        chk("job1_location", 32'(resp_location), 32'h0017);
        chk("job1_operand_stable", 32'(eng_dna_start), 32'h0010);
        step();
        chk("job1_resp_pulse", 32'(resp_valid), 32'd0);

        // Busy period: rr_ptr=2, only req[0] -> wraps to 0; req[2] arrives mid-WAIT
        set_op(0, 16'h0200, 16'd8, 12'h020);
        req[0] = 1'b1;
        step();
        chk("busy_ack0", 32'(req_ack), 32'b0001);
        req[0] = 1'b0;
        step();
        set_op(2, 16'h0100, 16'd5, 12'h010);
        req[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("busy_no_ack_in_wait", 32'(req_ack), 32'd0);
        end
        engine(1'b1, 1'b0, 1'b1, 16'h0055);
        step();
        engine(1'b0, 1'b0, 1'b0, 16'h0);
        chk("busy_resp0_valid", 32'(resp_valid), 32'b0001);
        chk("busy_resp0_error", 32'(resp_error), 32'd1);
        chk("busy_resp0_loc_forced0", 32'(resp_location), 32'd0);
        chk("busy_no_ack_in_report", 32'(req_ack), 32'd0);
        step();
        chk("busy_idle_no_ack", 32'(req_ack), 32'd0);
        step();
        chk("busy_ack2", 32'(req_ack), 32'b0100);
        chk("busy_job2_start", 32'(eng_dna_start), 32'h0100);
        req[2] = 1'b0;
        step();
        engine(1'b1, 1'b1, 1'b0, 16'h1234);
        step();
        engine(1'b0, 1'b0, 1'b0, 16'h0);
        chk("busy_resp2_valid", 32'(resp_valid), 32'b0100);
        chk("busy_resp2_loc", 32'(resp_location), 32'h1234);
        step();

        // Zero-length job on requester 3 (rr_ptr=3)
        set_op(3, 16'h0300, 16'd0, 12'h030);
        req[3] = 1'b1;
        step();
        chk("zero_eng_ready", 32'(eng_ready), 32'd0);
        chk("zero_ack", 32'(req_ack), 32'b1000);
        chk("zero_resp_valid", 32'(resp_valid), 32'b1000);
        chk("zero_error", 32'(resp_error), 32'd1);
        chk("zero_found", 32'(resp_found), 32'd0);
        req[3] = 1'b0;
        step();
        chk("zero_after_ready", 32'(eng_ready), 32'd0);
        chk("zero_after_resp", 32'(resp_valid), 32'd0);

        // eng_done while IDLE is ignored
        engine(1'b1, 1'b1, 1'b0, 16'h0099);
        step();
        engine(1'b0, 1'b0, 1'b0, 16'h0);
        step();
        chk("idle_done_ignored", 32'(resp_valid), 32'd0);

        // Reset mid-WAIT aborts the job
        set_op(1, 16'h0400, 16'd4, 12'h040);
        req[1] = 1'b1;
        step();
        chk("abort_ack", 32'(req_ack), 32'b0010);
        req[1] = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("abort_eng_reset", 32'(eng_reset), 32'd1);
        step();
        reset = 1'b0;
        chk("abort_req_ack", 32'(req_ack), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_eng_ready", 32'(eng_ready), 32'd0);
        chk("abort_dna_start", 32'(eng_dna_start), 32'd0);
        engine(1'b1, 1'b1, 1'b0, 16'h0042);
        step();
        engine(1'b0, 1'b0, 1'b0, 16'h0);
        chk("abort_late_done_ignored", 32'(resp_valid), 32'd0);
        step();
        chk("abort_late_done_ignored2", 32'(resp_valid), 32'd0);

        // Round-robin from rr_ptr=0 with all four requests held
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
        for (int i = 0; i < N; i++) set_op(i, 16'(16'h1000 + i), 16'(i + 1), 12'(i));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 10 && req_ack == '0; c++) step();
            chk("rr_ack", 32'(req_ack), 32'(4'b0001 << rr_exp[g]));
            chk("rr_dna_start", 32'(eng_dna_start), 32'h1000 + 32'(rr_exp[g]));
            step();
            engine(1'b1, 1'b0, 1'b0, 16'h0);
            step();
            engine(1'b0, 1'b0, 1'b0, 16'h0);
            chk("rr_resp_valid", 32'(resp_valid), 32'(4'b0001 << rr_exp[g]));
            step();
        end
        req = '0;
        step();

`ifdef SEARCH_TIMEOUT_EN
        // Engine never finishes: watchdog fires TIMEOUT cycles into WAIT (rr_ptr=1, wraps to 0)
        set_op(0, 16'h0500, 16'd9, 12'h050);
        req[0] = 1'b1;
        for (int c = 0; c < 10 && req_ack == '0; c++) step();
        chk("to_ack", 32'(req_ack), 32'b0001);
        req[0] = 1'b0;
        step();
        for (int c = 0; c < TO - 1; c++) step();
        chk("to_no_early_reset", 32'(eng_reset), 32'd0);
        step();
        chk("to_eng_reset", 32'(eng_reset), 32'd1);
        chk("to_no_resp_yet", 32'(resp_valid), 32'd0);
        step();
        chk("to_reset_pulse", 32'(eng_reset), 32'd0);
        chk("to_resp_valid", 32'(resp_valid), 32'b0001);
        chk("to_resp_error", 32'(resp_error), 32'd1);
        chk("to_resp_found", 32'(resp_found), 32'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
